// File: rtl/video_pkg.sv
// Shared constants and types for the video fetch path.
package video_pkg;

    localparam int VF_WORDS_DEF = 4;
    localparam int VF_DW        = 16;
    localparam int VF_STAT_W    = 8;

    typedef logic [VF_WORDS_DEF*VF_DW-1:0] vf_group_t;

endpackage

// File: rtl/video_satcnt.sv
// Generic saturating counter; clear has priority over increment.
module video_satcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/video_fetch_buf.sv
// Double-buffered DRAM word collector feeding the pixel renderer.
// Optional underrun statistics counter under VIDEO_FETCH_STATS_EN.
module video_fetch_buf
    import video_pkg::*;
#(
    parameter int WORDS = VF_WORDS_DEF,
    parameter int DW    = VF_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_start,
    input  logic                  int_start,
    input  logic                  video_strobe,
    input  logic [DW-1:0]         dram_rddata,
    input  logic                  fetch_sync,
    output logic [WORDS*DW-1:0]   fetch_data,
    output logic                  fetch_valid,
    output logic                  underrun,
    output logic                  overflow,
    output logic [VF_STAT_W-1:0]  ur_count
);

    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] FULL = CW'(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [DW-1:0]       shadow_q [WORDS];
    logic [DW-1:0]       shadow_d [WORDS];
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [WORDS*DW-1:0] fetch_data_q, fetch_data_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                underrun_q, underrun_d;
    logic                overflow_q, overflow_d;

    logic                complete;
    logic                ur_inc;
    logic [WORDS*DW-1:0] group;

    assign complete = (wcnt_q == FULL) || ((wcnt_q == LAST) && video_strobe);
    assign ur_inc   = fetch_sync && !fetch_start && !complete;

    // The last word bypasses the shadow bank when it arrives with the sync.
    always_comb begin
        group = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if ((k == WORDS - 1) && (wcnt_q == LAST)) begin
                group[DW*k +: DW] = dram_rddata;
            end else begin
                group[DW*k +: DW] = shadow_q[k];
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < WORDS; k++) begin
            shadow_d[k] = shadow_q[k];
        end
        wcnt_d        = wcnt_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        underrun_d    = underrun_q;
        overflow_d    = overflow_q;

        if (fetch_start) begin
            wcnt_d     = '0;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
            if (video_strobe) begin
                shadow_d[0] = dram_rddata;
                wcnt_d      = CW'(1);
            end
        end else if (fetch_sync && complete) begin
            fetch_data_d  = group;
            fetch_valid_d = 1'b1;
            wcnt_d        = '0;
            if (video_strobe && (wcnt_q == FULL)) begin
                shadow_d[0] = dram_rddata;
                wcnt_d      = CW'(1);
            end
        end else begin
            if (fetch_sync) begin
                underrun_d = 1'b1;
            end
            if (video_strobe) begin
                if (wcnt_q < FULL) begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (wcnt_q == CW'(k)) shadow_d[k] = dram_rddata;
                    end
                    wcnt_d = wcnt_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                shadow_q[k] <= '0;
            end
            wcnt_q        <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            underrun_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            wcnt_q        <= wcnt_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            underrun_q    <= underrun_d;
            overflow_q    <= overflow_d;
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign underrun    = underrun_q;
    assign overflow    = overflow_q;

`ifdef VIDEO_FETCH_STATS_EN
    video_satcnt #(
        .W(VF_STAT_W)
    ) u_ur_cnt (
        .clk (clk),
        .rst (rst),
        .clr (int_start),
        .inc (ur_inc),
        .cnt (ur_count)
    );
`else
    logic unused_stats;
    assign unused_stats = int_start | ur_inc;
    assign ur_count     = '0;
`endif

endmodule

// File: tb/tb_video_fetch_buf.sv
// Scoreboard bench for video_fetch_buf against a queue-based group model.
module tb_video_fetch_buf;
    import video_pkg::*;

    localparam int W  = VF_WORDS_DEF;
    localparam int DW = VF_DW;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 fs  = 1'b0;
    logic                 is  = 1'b0;
    logic                 vs  = 1'b0;
    logic                 sy  = 1'b0;
    logic [DW-1:0]        d   = '0;
    logic [W*DW-1:0]      fetch_data;
    logic                 fetch_valid;
    logic                 underrun;
    logic                 overflow;
    logic [VF_STAT_W-1:0] ur_count;

    video_fetch_buf #(
        .WORDS(W),
        .DW   (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fs),
        .int_start   (is),
        .video_strobe(vs),
        .dram_rddata (d),
        .fetch_sync  (sy),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .underrun    (underrun),
        .overflow    (overflow),
        .ur_count    (ur_count)
    );

    always #18 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference state: pending words in arrival order, flags, last delivered group.
    vf_group_t     exp_q[$];
    logic [DW-1:0] m_sh[$];
    bit            m_ur, m_ov, m_val;
    vf_group_t     m_data;
    int            m_cnt;
    vf_group_t     sb_e;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sh.delete();
        exp_q.delete();
        m_ur = 0; m_ov = 0; m_val = 0; m_data = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit        inc;
        bit        comp;
        bit        was_full;
        vf_group_t grp;
        inc   = 0;
        m_val = 0;
        if (fs) begin
            m_sh.delete();
            m_ur = 0;
            m_ov = 0;
            if (vs) m_sh.push_back(d);
        end else begin
            comp = (m_sh.size() == W) || ((m_sh.size() == W - 1) && vs);
            if (sy && comp) begin
                grp = '0;
                for (int i = 0; i < m_sh.size(); i++) grp[DW*i +: DW] = m_sh[i];
                if (m_sh.size() == W - 1) grp[DW*(W-1) +: DW] = d;
                was_full = (m_sh.size() == W);
                m_sh.delete();
                if (vs && was_full) m_sh.push_back(d);
                exp_q.push_back(grp);
                m_data = grp;
                m_val  = 1;
            end else begin
                if (sy) begin
                    m_ur = 1;
                    inc  = 1;
                end
                if (vs) begin
                    if (m_sh.size() < W) m_sh.push_back(d);
                    else                 m_ov = 1;
                end
            end
        end
`ifdef VIDEO_FETCH_STATS_EN
        if (is)                     m_cnt = 0;
        else if (inc && m_cnt < 255) m_cnt++;
`endif
    endtask

    task automatic cyc(bit f, bit s, bit v, logic [DW-1:0] dd, bit i = 0);
        @(negedge clk);
        fs = f; sy = s; vs = v; d = dd; is = i;
        model_step();
        @(posedge clk);
        #1;
        chk("fetch_valid", fetch_valid, m_val);
        chk("underrun",    underrun,    m_ur);
        chk("overflow",    overflow,    m_ov);
        chk("fetch_data",  fetch_data,  m_data);
        chk("ur_count",    ur_count,    m_cnt[7:0]);
    endtask

    task automatic strobe(logic [DW-1:0] dd);
        cyc(0, 0, 1, dd);
    endtask

    // Monitor: every presented group must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && fetch_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL sb_unexpected: got %h want no group", fetch_data);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_group", fetch_data, sb_e);
            end
        end
    end

    initial begin
        model_reset();
        #5;
        chk("rst_data",  fetch_data,  64'h0);
        chk("rst_valid", fetch_valid, 1'b0);
        chk("rst_ur",    underrun,    1'b0);
        chk("rst_ov",    overflow,    1'b0);
        chk("rst_cnt",   ur_count,    8'h0);
        @(negedge clk);
        rst = 1'b0;

        // Plain four-word group.
        cyc(1, 0, 0, 0);
        strobe(16'h1111); strobe(16'h2222); strobe(16'h3333); strobe(16'h4444);
        cyc(0, 1, 0, 0);
        chk("t1_data", fetch_data, 64'h4444_3333_2222_1111);
        chk("t1_ur",   underrun,   1'b0);
        cyc(0, 0, 0, 0);
        chk("t1_pulse", fetch_valid, 1'b0);

        // Last word bypasses shadow.
        strobe(16'hAAAA); strobe(16'hBBBB); strobe(16'hCCCC);
        cyc(0, 1, 1, 16'hDDDD);
        chk("t2_data", fetch_data, 64'hDDDD_CCCC_BBBB_AAAA);
        cyc(0, 0, 0, 0);

        // Underrun keeps collection alive.
        strobe(16'h0101); strobe(16'h0202);
        cyc(0, 1, 0, 0);
        chk("t3_ur",   underrun,   1'b1);
        chk("t3_hold", fetch_data, 64'hDDDD_CCCC_BBBB_AAAA);
        strobe(16'h0303); strobe(16'h0404);
        cyc(0, 1, 0, 0);
        chk("t3_data",   fetch_data, 64'h0404_0303_0202_0101);
        chk("t3_sticky", underrun,   1'b1);

        // Overflow drops the fifth word.
        cyc(1, 0, 0, 0);
        chk("t4_clr", underrun, 1'b0);
        strobe(16'h1001); strobe(16'h1002); strobe(16'h1003); strobe(16'h1004);
        strobe(16'h1005);
        chk("t4_ov", overflow, 1'b1);
        cyc(0, 1, 1, 16'h9999);
        chk("t4_data", fetch_data, 64'h1004_1003_1002_1001);
        strobe(16'h2002); strobe(16'h2003); strobe(16'h2004);
        cyc(0, 1, 0, 0);
        chk("t4_next", fetch_data, 64'h2004_2003_2002_9999);

        // fetch_start beats fetch_sync.
        strobe(16'h3001); strobe(16'h3002); strobe(16'h3003); strobe(16'h3004);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 16'h7777);
        cyc(0, 0, 1, 16'h7778);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 16'h5A5A);
        chk("t5_valid", fetch_valid, 1'b0);
        chk("t5_ur",    underrun,    1'b0);
        chk("t5_ov",    overflow,    1'b0);
        strobe(16'h6001); strobe(16'h6002); strobe(16'h6003);
        cyc(0, 1, 0, 0);
        chk("t5_data", fetch_data, 64'h6003_6002_6001_5A5A);

`ifdef VIDEO_FETCH_STATS_EN
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, 0, 0);
        chk("t6_sat", ur_count, 8'hFF);
        cyc(0, 0, 0, 0, 1);
        chk("t6_clr", ur_count, 8'h00);
        cyc(0, 1, 0, 0, 1);
        chk("t6_clr_win", ur_count, 8'h00);
`else
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 0, 0);
        chk("t6_tied", ur_count, 8'h00);
`endif

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            cyc(($urandom_range(15) == 0), ($urandom_range(3) == 0),
                ($urandom_range(1) == 0), DW'($urandom),
                ($urandom_range(31) == 0));
        end

        // Build up a group, then reset asynchronously mid-cycle.
        cyc(1, 0, 0, 0);
        strobe(16'hBEEF); strobe(16'hCAFE); strobe(16'hF00D); strobe(16'h1234);
        cyc(0, 1, 0, 0);
        strobe(16'h5555);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_data",  fetch_data,  64'h0);
        chk("arst_valid", fetch_valid, 1'b0);
        chk("arst_ur",    underrun,    1'b0);
        chk("arst_ov",    overflow,    1'b0);
        chk("arst_cnt",   ur_count,    8'h0);
        model_reset();
        fs = 0; sy = 0; vs = 0; is = 0;
        @(negedge clk);
        rst = 1'b0;
        // Partial word from before reset must be gone.
        strobe(16'h0A0A); strobe(16'h0B0B); strobe(16'h0C0C);
        cyc(0, 1, 0, 0);
        chk("arst_ur_after", underrun, 1'b1);
        strobe(16'h0D0D);
        cyc(0, 1, 0, 0);
        chk("arst_data_after", fetch_data, 64'h0D0D_0C0C_0B0B_0A0A);

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/video_fetch_buf.md
Name: video_fetch_buf

Overview:
- Downstream neighbour of the video address generator.
- Captures the 16-bit DRAM words the arbiter returns for each video_next slot and assembles them into fixed-size groups.
- Hands each completed group to the pixel renderer at the renderer's fetch_sync boundary.
- Double-buffered: a shadow bank fills while the output register holds the group currently being rendered. Underrun and overflow are flagged.

Parameters:
- WORDS, 4, DRAM words per group; legal values 2 or 4.
- DW, 16, DRAM word width in bits.

Ports:
- clk, in, 1, 28 MHz system clock.
- rst, in, 1, asynchronous active-high reset.
- fetch_start, in, 1, line start (line_start & vpix, registered upstream); restarts group collection.
- int_start, in, 1, frame start pulse; clears statistics (optional feature only).
- video_strobe, in, 1, dram_rddata holds a valid video word this cycle.
- dram_rddata, in, DW, DRAM read data.
- fetch_sync, in, 1, one-cycle renderer request for the next group.
- fetch_data, out, WORDS*DW, group presented to the renderer.
- fetch_valid, out, 1, one-cycle pulse: fetch_data updated this cycle.
- underrun, out, 1, sticky: a fetch_sync found an incomplete group.
- overflow, out, 1, sticky: a word arrived with the shadow bank already full.
- ur_count, out, 8, underrun statistics (optional feature).

Behaviour:
- Reset values:
  - fetch_data = 0, fetch_valid = 0, underrun = 0, overflow = 0, ur_count = 0.
  - Shadow word count wcnt = 0; shadow bank contents are don't-care.
- Word storage:
  - On video_strobe with wcnt < WORDS: dram_rddata is written to shadow[wcnt], then wcnt increments.
  - Word k of a group maps to fetch_data[DW*k +: DW]. Word 0 is the first word after fetch_start or after a transfer.
- Complete condition: wcnt == WORDS, or (wcnt == WORDS-1 and video_strobe this cycle). The second case is the bypass: the last word goes straight to fetch_data.
- On fetch_sync with complete:
  - fetch_data receives the shadow bank (plus the bypassed word) at the next clk edge.
  - fetch_valid = 1 for exactly that one cycle.
  - wcnt = 0.
- On fetch_sync with incomplete:
  - fetch_data holds its previous value; fetch_valid stays 0.
  - underrun is set.
  - wcnt and shadow contents are kept, so collection continues.
- Overflow: video_strobe with wcnt == WORDS and no fetch_sync this cycle → word dropped, overflow set, wcnt stays WORDS.
- Strobe coinciding with a transfer of an already-full bank (wcnt == WORDS and fetch_sync): the old group transfers, the new word goes to shadow[0], wcnt = 1.
- fetch_start:
  - Has priority over fetch_sync: no transfer that cycle.
  - wcnt = 0; underrun and overflow cleared.
  - A video_strobe in the same cycle stores to shadow[0], giving wcnt = 1.
  - fetch_data is not cleared.
- Latency: fetch_sync → fetch_valid/fetch_data is one clk.
- wcnt width is clog2(WORDS)+1 bits; it never exceeds WORDS and never wraps.
- Reset asserted mid-group discards all partial state immediately, without waiting for a clock edge.

Optional Feature:
- Macro: VIDEO_FETCH_STATS_EN.
- Defined:
  - ur_count increments by 1 on every fetch_sync that sets or re-sets underrun.
  - Saturates at 8'hFF.
  - Cleared on int_start; int_start wins over a simultaneous increment.
- Undefined: ur_count is tied to 0, int_start is ignored, and no counter logic is synthesised.

Decomposition:
- Shared package video_pkg holds:
  - VF_WORDS_DEF = 4, VF_DW = 16, VF_STAT_W = 8.
  - A typedef for a WORDS*DW group word.
- Sub-module video_satcnt: a generic saturating counter with clear and increment; clear has priority. It is instantiated only under VIDEO_FETCH_STATS_EN.

Test Plan:
1. Reset, fetch_start, strobes 16'h1111, 2222, 3333, 4444, then fetch_sync → next cycle fetch_data = 64'h4444_3333_2222_1111, fetch_valid = 1 for 1 cycle, underrun = 0.
2. Bypass: 3 strobes (A, B, C), then strobe 16'hDDDD in the same cycle as fetch_sync → fetch_data = DDDD_CCCC_BBBB_AAAA, fetch_valid pulses, wcnt = 0.
3. Underrun: 2 strobes, fetch_sync → fetch_valid = 0, fetch_data unchanged, underrun = 1. Then 2 more strobes and fetch_sync → transfer of all 4 words, underrun remains 1 until fetch_start.
4. Overflow: 5 strobes with no sync → overflow = 1, and the next sync delivers words 1–4 (the 5th is dropped). A strobe coinciding with that sync → wcnt = 1.
5. fetch_start with simultaneous fetch_sync and strobe 16'h5A5A → no fetch_valid, flags clear, shadow[0] = 5A5A, wcnt = 1.
6. With VIDEO_FETCH_STATS_EN: 300 underrun syncs → ur_count = 8'hFF. int_start → 0; int_start coinciding with an underrun sync → 0. Without the macro, ur_count stays 0. Additionally, assert rst mid-group → all outputs 0 without waiting for clk.
